shift_pipe: RTL

- Parametrised, pipelined barrel shifter for the MIPS datapath.
- Replaces fixed shift-by-constant logic with variable-amount SLL/SRL/SRA (optional ROTR).
- Uses valid/ready handshakes so it can sit in the EX stage or behind a multi-cycle ALU issue slot.
- Stage count is selectable for timing closure.

---
 rtl/shift_pkg.sv | 35 +++
 rtl/shift_pipe_level.sv | 39 +++
 rtl/shift_pipe.sv | 135 +++++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared op encodings and stage/level split helpers for shift_pipe
//
// Purpose: op encodings, the op type and the levels-per-stage helpers used
//          by shift_pipe and shift_pipe_level.
// Ports:   none (package).
package shift_pkg;

    typedef logic [1:0] shift_op_t;

    localparam shift_op_t SHIFT_OP_SLL  = 2'b00;
    localparam shift_op_t SHIFT_OP_SRL  = 2'b01;
    localparam shift_op_t SHIFT_OP_SRA  = 2'b10;
    localparam shift_op_t SHIFT_OP_ROTR = 2'b11;

    // Number of mux levels placed in a given stage; the first
    // (shamt_w % stages) stages each take one extra level.
    function automatic int stage_levels(input int shamt_w, input int stages, input int stage);
        int base;
        int extra;
        base  = shamt_w / stages;
        extra = shamt_w % stages;
        return base + ((stage < extra) ? 1 : 0);
    endfunction

    // Index of the first mux level handled by a given stage.
    function automatic int stage_first(input int shamt_w, input int stages, input int stage);
        int first;
        first = 0;
        for (int i = 0; i < stage; i++) begin
            first += stage_levels(shamt_w, stages, i);
        end
        return first;
    endfunction

endpackage

// File: rtl/shift_pipe_level.sv
// rtl/shift_pipe_level.sv - one combinational mux level of the barrel shifter
//
// Purpose: shifts data by DIST bit positions when en is set, direction and
//          fill chosen by op. Rotate muxing exists only with
//          SHIFT_PIPE_ROTATE_EN defined; otherwise op 11 behaves as SLL.
// Ports:
//   data    in   DATA_W  partial result from the previous level
//   en      in   1       shift-amount bit for this level
//   op      in   2       shift operation
//   fill    in   1       sign bit used as SRA fill
//   shifted out  DATA_W  result of this level
module shift_pipe_level
    import shift_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DIST   = 1
) (
    input  logic [DATA_W-1:0] data,
    input  logic              en,
    input  shift_op_t         op,
    input  logic              fill,
    output logic [DATA_W-1:0] shifted
);

    always_comb begin
        shifted = data;
        if (en) begin
            case (op)
                SHIFT_OP_SRL:  shifted = data >> DIST;
                SHIFT_OP_SRA:  shifted = {{DIST{fill}}, data[DATA_W-1:DIST]};
`ifdef SHIFT_PIPE_ROTATE_EN
                SHIFT_OP_ROTR: shifted = {data[DIST-1:0], data[DATA_W-1:DIST]};
`endif
                default:       shifted = data << DIST;
            endcase
        end
    end

endmodule

// File: rtl/shift_pipe.sv
// rtl/shift_pipe.sv - pipelined variable-amount barrel shifter with valid/ready handshakes
//
// Purpose: SLL/SRL/SRA (ROTR with SHIFT_PIPE_ROTATE_EN defined) over
//          SHAMT_W mux levels split across PIPE_STAGES register stages.
//          Latency is PIPE_STAGES cycles; one result per cycle when unstalled.
// Ports:
//   clk       in   1        system clock, rising edge
//   rst_n     in   1        asynchronous active-low reset
//   in_valid  in   1        request present
//   in_ready  out  1        request accepted this cycle when in_valid is high
//   in_data   in   DATA_W   operand
//   in_shamt  in   SHAMT_W  shift amount
//   in_op     in   2        00 SLL, 01 SRL, 10 SRA, 11 ROTR or SLL
//   out_valid out  1        result present
//   out_ready in   1        consumer accepts result
//   out_data  out  DATA_W   shifted result
module shift_pipe
    import shift_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int SHAMT_W     = $clog2(DATA_W),
    parameter int PIPE_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  shift_op_t          in_op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data
);

    localparam int LAST = PIPE_STAGES - 1;

    // Stage registers
    logic [PIPE_STAGES-1:0]              v;
    logic [DATA_W-1:0]                   d_q    [PIPE_STAGES];
    logic [PIPE_STAGES-1:0][SHAMT_W-1:0] sh_q;
    shift_op_t                           op_q   [PIPE_STAGES];
    logic [PIPE_STAGES-1:0]              fill_q;

    // Per-stage load enables and next values
    logic [PIPE_STAGES-1:0]              ld;
    logic [PIPE_STAGES-1:0]              up_valid;
    logic [DATA_W-1:0]                   nxt_data  [PIPE_STAGES];
    logic [SHAMT_W-1:0]                  up_shamt  [PIPE_STAGES];
    shift_op_t                           up_op     [PIPE_STAGES];
    logic [PIPE_STAGES-1:0]              up_fill;

    // A stage may load when it is empty or its contents leave this cycle;
    // walking from the output back lets bubbles collapse under backpressure.
    always_comb begin : load_chain
        logic downstream_ok;
        ld            = '0;
        downstream_ok = out_ready;
        for (int s = LAST; s >= 0; s--) begin
            downstream_ok = !v[s] || downstream_ok;
            ld[s]         = downstream_ok;
        end
    end

    assign in_ready  = ld[0];
    assign out_valid = v[LAST];
    assign out_data  = d_q[LAST];

    for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
        localparam int FIRST = stage_first(SHAMT_W, PIPE_STAGES, s);
        localparam int NLEV  = stage_levels(SHAMT_W, PIPE_STAGES, s);

        logic [DATA_W-1:0] chain [NLEV+1];

        if (s == 0) begin : g_head
            // The SRA fill bit is the operand sign, captured once here.
            assign up_valid[s] = in_valid;
            assign chain[0]    = in_data;
            assign up_shamt[s] = in_shamt;
            assign up_op[s]    = in_op;
            assign up_fill[s]  = in_data[DATA_W-1];
        end else begin : g_body
            assign up_valid[s] = v[s-1];
            assign chain[0]    = d_q[s-1];
            assign up_shamt[s] = sh_q[s-1];
            assign up_op[s]    = op_q[s-1];
            assign up_fill[s]  = fill_q[s-1];
        end

        for (genvar j = 0; j < NLEV; j++) begin : g_level
            shift_pipe_level #(
                .DATA_W (DATA_W),
                .DIST   (1 << (FIRST + j))
            ) u_level (
                .data    (chain[j]),
                .en      (up_shamt[s][FIRST + j]),
                .op      (up_op[s]),
                .fill    (up_fill[s]),
                .shifted (chain[j+1])
            );
        end

        assign nxt_data[s] = chain[NLEV];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v      <= '0;
            sh_q   <= '0;
            fill_q <= '0;
            for (int s = 0; s < PIPE_STAGES; s++) begin
                d_q[s]  <= '0;
                op_q[s] <= SHIFT_OP_SLL;
            end
        end else begin
            for (int s = 0; s < PIPE_STAGES; s++) begin
                if (ld[s]) begin
                    v[s] <= up_valid[s];
                    if (up_valid[s]) begin
                        d_q[s]    <= nxt_data[s];
                        sh_q[s]   <= up_shamt[s];
                        op_q[s]   <= up_op[s];
                        fill_q[s] <= up_fill[s];
                    end
                end
            end
        end
    end

    // Shift bits already consumed and the last stage's control fields are
    // carried only for uniformity; nothing downstream reads them.
    logic unused_ctrl;
    assign unused_ctrl = ^{sh_q, fill_q[LAST], op_q[LAST]};

endmodule
